firefly_rx: RTL and testbench

FIREFLY_RX -- requirements
Module: firefly_rx

---
 rtl/firefly_pkg.sv | 15 +
 rtl/firefly_sync.sv | 30 +++
 rtl/firefly_rx.sv | 127 ++++++++++++
 tb/tb_firefly_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/firefly_pkg.sv
// Shared constants and FSM state encoding for the firefly flash link.
// Transmitter and receiver both pull the nominal flash width from here.
package firefly_pkg;

    typedef logic [1:0] state_t;

    localparam state_t WAIT_LOW = 2'd0;
    localparam state_t IDLE     = 2'd1;
    localparam state_t HIGH     = 2'd2;
    localparam state_t LONG     = 2'd3;

    localparam int NOMINAL_DEF = 15000;
    localparam int TOL_DEF     = 500;

endpackage

// File: rtl/firefly_sync.sv
// Two-flop synchronizer for the asynchronous flash line plus rise/fall
// detection on the synchronized level.
module firefly_sync (
    input  logic clk,
    input  logic rst,
    input  logic f1,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= f1;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign s    = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/firefly_rx.sv
// Firefly flash receiver: measures high-pulse width on f1 and classifies it.
// Optional valid-flash counter enabled by FIREFLY_FLASH_CNT_EN.
module firefly_rx
    import firefly_pkg::*;
#(
    parameter int NOMINAL = NOMINAL_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f1,
    output logic          flash_ok,
    output logic          err_short,
    output logic          err_long,
`ifdef FIREFLY_FLASH_CNT_EN
    output logic [7:0]    flash_cnt,
`endif
    output logic [CW-1:0] last_width
);

    localparam logic [CW-1:0] LO    = CW'(NOMINAL - TOL);
    localparam logic [CW-1:0] HI    = CW'(NOMINAL + TOL);
    localparam logic [CW-1:0] LIMIT = CW'(NOMINAL + TOL + 1);
    localparam logic [CW-1:0] ONES  = '1;

    if (NOMINAL + TOL >= (2 ** CW) - 1) begin : g_bad_cfg
        $error("firefly_rx: NOMINAL+TOL must be below 2^CW-1");
    end

    logic s, rise, fall;

    firefly_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .f1   (f1),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] width_q, width_d;
    logic          ok_q, ok_d, short_q, short_d, long_q, long_d;
    logic [1:0]    warm_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        ok_d    = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            // Synchronizer output is forced low for two cycles after reset, so
            // only trust s once the pipeline holds real samples of f1.
            WAIT_LOW: if (warm_q[1] && !s) state_d = IDLE;
            IDLE: begin
                if (rise) begin
                    cnt_d   = CW'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    width_d = cnt_q;
                    ok_d    = (cnt_q >= LO) && (cnt_q <= HI);
                    short_d = !((cnt_q >= LO) && (cnt_q <= HI));
                    state_d = IDLE;
                end else if (s) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == LIMIT) begin
                        long_d  = 1'b1;
                        state_d = LONG;
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    width_d = cnt_q;
                    state_d = IDLE;
                end else if (s && cnt_q != ONES) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            width_q <= '0;
            ok_q    <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            ok_q    <= ok_d;
            short_q <= short_d;
            long_q  <= long_d;
            warm_q  <= {warm_q[0], 1'b1};
        end
    end

    assign flash_ok   = ok_q;
    assign err_short  = short_q;
    assign err_long   = long_q;
    assign last_width = width_q;

`ifdef FIREFLY_FLASH_CNT_EN
    logic [7:0] fcnt_q;

    always_ff @(posedge clk) begin
        if (rst)       fcnt_q <= '0;
        else if (ok_d) fcnt_q <= fcnt_q + 8'd1;
    end

    assign flash_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_firefly_rx.sv
// Bench for firefly_rx: run-length reference model on the sampled f1 line,
// compared every cycle, plus literal checks after each directed scenario.
module tb_firefly_rx;

    localparam int NOM   = 1500;
    localparam int TOL   = 50;
    localparam int CW    = 11;
    localparam int LO    = NOM - TOL;
    localparam int HI    = NOM + TOL;
    localparam int LIMIT = HI + 1;
    localparam int ONES  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          f1  = 1'b0;
    logic          flash_ok, err_short, err_long;
    logic [CW-1:0] last_width;
`ifdef FIREFLY_FLASH_CNT_EN
    logic [7:0]    flash_cnt;
`endif

    firefly_rx #(.NOMINAL(NOM), .TOL(TOL), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .f1         (f1),
        .flash_ok   (flash_ok),
        .err_short  (err_short),
        .err_long   (err_long),
`ifdef FIREFLY_FLASH_CNT_EN
        .flash_cnt  (flash_cnt),
`endif
        .last_width (last_width)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit ok;
        bit sh;
        bit lg;
        bit wv;
        int w;
    } ev_t;

    // Reference: events are decided on the sample of f1 taken at an edge and
    // become visible on the outputs two edges later.
    ev_t p0, p1;
    bit  need_low, lng;
    int  run;
    bit  e_ok, e_sh, e_lg;
    int  e_w, e_fc;
    int  nchk, nerr, cyc, n_ok, n_sh, n_lg;

    task automatic clear_ev(output ev_t e);
        e.ok = 0; e.sh = 0; e.lg = 0; e.wv = 0; e.w = 0;
    endtask

    task automatic model_step();
        ev_t e;
        if (rst) begin
            need_low = 1; run = 0; lng = 0;
            clear_ev(p0); clear_ev(p1);
            e_ok = 0; e_sh = 0; e_lg = 0; e_w = 0; e_fc = 0;
        end else begin
            e_ok = p1.ok; e_sh = p1.sh; e_lg = p1.lg;
            if (p1.wv) e_w = p1.w;
            if (p1.ok) e_fc = (e_fc + 1) % 256;
            p1 = p0;
            clear_ev(e);
            if (need_low) begin
                if (!f1) need_low = 0;
            end else if (f1) begin
                run++;
                if (run == LIMIT) begin
                    e.lg = 1;
                    lng  = 1;
                end
            end else if (run > 0) begin
                e.wv = 1;
                e.w  = (run > ONES) ? ONES : run;
                if (!lng) begin
                    if (run >= LO && run <= HI) e.ok = 1;
                    else                        e.sh = 1;
                end
                run = 0;
                lng = 0;
            end
            p0 = e;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 20)
                $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("flash_ok", 32'(flash_ok), 32'(e_ok));
        check("err_short", 32'(err_short), 32'(e_sh));
        check("err_long", 32'(err_long), 32'(e_lg));
        check("last_width", 32'(last_width), e_w);
        check("onehot", 32'($countones({flash_ok, err_short, err_long}) > 1), 0);
`ifdef FIREFLY_FLASH_CNT_EN
        check("flash_cnt", 32'(flash_cnt), e_fc);
`endif
        if (flash_ok === 1'b1)  n_ok++;
        if (err_short === 1'b1) n_sh++;
        if (err_long === 1'b1)  n_lg++;
    endtask

    task automatic flash(input int w, input int gap);
        f1 = 1'b1;
        repeat (w) tick();
        f1 = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic counts(input string tag, input int ok, input int sh, input int lg);
        check({tag, "_nok"}, n_ok, ok);
        check({tag, "_nshort"}, n_sh, sh);
        check({tag, "_nlong"}, n_lg, lg);
    endtask

    initial begin
        int w, kind;
        nchk = 0; nerr = 0; cyc = 0; n_ok = 0; n_sh = 0; n_lg = 0;
        need_low = 1; run = 0; lng = 0;
        clear_ev(p0); clear_ev(p1);
        e_ok = 0; e_sh = 0; e_lg = 0; e_w = 0; e_fc = 0;

        rst = 1'b1; f1 = 1'b0;
        repeat (3) tick();
        check("rst_width", 32'(last_width), 0);
        check("rst_flags", 32'({flash_ok, err_short, err_long}), 0);
        rst = 1'b0;
        repeat (6) tick();

        flash(NOM, 20);
        counts("nominal", 1, 0, 0);
        check("nominal_width", 32'(last_width), NOM);
        check("nominal_model", e_w, 1500);
`ifdef FIREFLY_FLASH_CNT_EN
        check("nominal_cnt", 32'(flash_cnt), 1);
`endif

        flash(LO - 1, 20);
        counts("below_lo", 1, 1, 0);
        check("below_lo_width", 32'(last_width), 1449);
        flash(LO, 20);
        counts("at_lo", 2, 1, 0);
        check("at_lo_width", 32'(last_width), 1450);
        flash(HI, 20);
        counts("at_hi", 3, 1, 0);
        flash(HI + 2, 20);
        counts("over_hi", 3, 1, 1);
        check("over_hi_width", 32'(last_width), 1552);
        flash(2100, 20);
        counts("saturate", 3, 1, 2);
        check("saturate_width", 32'(last_width), 2047);

        // Line already high when reset releases: nothing measured until it drops.
        f1 = 1'b1; rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (200) tick();
        f1 = 1'b0;
        repeat (20) tick();
        counts("high_at_reset", 3, 1, 2);
        check("high_at_reset_width", 32'(last_width), 0);
        flash(NOM, 20);
        counts("after_high_reset", 4, 1, 2);
        check("after_high_reset_width", 32'(last_width), 1500);

        // Reset in the middle of a flash drops the partial measurement.
        f1 = 1'b1;
        repeat (800) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (100) tick();
        f1 = 1'b0;
        repeat (20) tick();
        counts("mid_reset", 4, 1, 2);
        check("mid_reset_width", 32'(last_width), 0);
        flash(NOM, 20);
        counts("after_mid_reset", 5, 1, 2);

        flash(NOM, 1);
        flash(NOM, 20);
        counts("one_gap", 7, 1, 2);

        for (int i = 0; i < 12; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       w = $urandom_range(1, 60);
                1:       w = $urandom_range(LO - 3, LO + 3);
                2:       w = $urandom_range(HI - 3, HI + 3);
                default: w = $urandom_range(LO, HI);
            endcase
            if (w == LIMIT) w = LIMIT + 1;
            flash(w, $urandom_range(1, 8));
        end
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
